// File: rtl/ee354_bin2bcd_pkg.sv
// ee354_bin2bcd_pkg: shared state encoding and widths for the binary-to-BCD converter.
//   STATE_W  width of the one-hot state vector {q_Done, q_Shift, q_I}
//   DIG_W    width of one BCD digit
//   state_t  one-hot states I, SHIFT, DONE
package ee354_bin2bcd_pkg;
    localparam int STATE_W = 3;
    localparam int DIG_W   = 4;
    typedef enum logic [STATE_W-1:0] {
        I     = 3'b001,
        SHIFT = 3'b010,
        DONE  = 3'b100
    } state_t;
endpackage

// File: rtl/ee354_bin2bcd_if.sv
// ee354_bin2bcd_if: Start/Ack handshake, single-step enable, operand and result bus.
//   master: drives SCEN, Start, Ack, Bin; receives Ones, Tens, Hundreds, q_I, q_Shift, q_Done
//   slave : the converter side of the same signals
interface ee354_bin2bcd_if #(
    parameter int WIDTH = 8
);
    import ee354_bin2bcd_pkg::*;
    logic             SCEN;
    logic             Start;
    logic             Ack;
    logic [WIDTH-1:0] Bin;
    logic [DIG_W-1:0] Ones;
    logic [DIG_W-1:0] Tens;
    logic [DIG_W-1:0] Hundreds;
    logic             q_I;
    logic             q_Shift;
    logic             q_Done;
    modport master (
        output SCEN, Start, Ack, Bin,
        input  Ones, Tens, Hundreds, q_I, q_Shift, q_Done
    );
    modport slave (
        input  SCEN, Start, Ack, Bin,
        output Ones, Tens, Hundreds, q_I, q_Shift, q_Done
    );
endinterface

// File: rtl/ee354_add3.sv
// ee354_add3: double-dabble digit correction, adds 3 to a BCD digit that is 5 or more.
//   d_i  BCD digit before the shift
//   d_o  corrected digit (never overflows since the add only happens below 10)
module ee354_add3
    import ee354_bin2bcd_pkg::*;
(
    input  logic [DIG_W-1:0] d_i,
    output logic [DIG_W-1:0] d_o
);
    always_comb d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/ee354_bin2bcd.sv
// ee354_bin2bcd: sequential shift-and-add-3 binary-to-BCD converter with Start/Ack handshake.
//   Clk    system clock, rising edge
//   Reset  synchronous active-high reset
//   bus    slave side of ee354_bin2bcd_if: SCEN, Start, Ack, Bin in;
//          Ones, Tens, Hundreds (registered result) and one-hot q_I, q_Shift, q_Done out
module ee354_bin2bcd
    import ee354_bin2bcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input logic              Clk,
    input logic              Reset,
    ee354_bin2bcd_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int BW = DIG_W * NDIG;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3*DIG_W-1:0]  res_q, res_d;
    logic [BW+WIDTH-1:0] sh;

    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        ee354_add3 u_add3 (
            .d_i(bcd_q[g*DIG_W +: DIG_W]),
            .d_o(bcd_adj[g*DIG_W +: DIG_W])
        );
    end

    // Corrected digits and the remaining binary shift together as one register.
    assign sh = {bcd_adj, bin_q} << 1;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            I: begin
                bin_d = bus.Bin;
                bcd_d = '0;
                cnt_d = '0;
                if (bus.Start) state_d = SHIFT;
            end
            SHIFT: if (bus.SCEN) begin
                {bcd_d, bin_d} = sh;
                cnt_d          = cnt_q + 1'b1;
                // Last iteration: publish the post-shift digits, not the current ones.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_d   = sh[WIDTH +: 3*DIG_W];
                    state_d = DONE;
                end
            end
            DONE: if (bus.Ack) state_d = I;
            default: state_d = I;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= I;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign bus.Ones     = res_q[0 +: DIG_W];
    assign bus.Tens     = res_q[DIG_W +: DIG_W];
    assign bus.Hundreds = res_q[2*DIG_W +: DIG_W];
    assign bus.q_I      = state_q[0];
    assign bus.q_Shift  = state_q[1];
    assign bus.q_Done   = state_q[2];
endmodule
